// File: rtl/ps2_kbd_tx.sv
// ps2_kbd_tx
// PS/2 device-side (keyboard) transmitter. Scan-code bytes are queued in a
// small FIFO. Each byte is sent as an 11-bit frame: start bit, 8 data bits
// LSB first, parity, stop bit. The PS/2 clock is built from CLK_DIV-cycle
// half-periods of clk, and an idle gap follows every frame.
//
// Ports
//   clk           system clock, rising edge
//   rst_n         asynchronous reset, active low
//   code_valid    byte offered on code_data / code_err
//   code_data     scan-code byte
//   code_err      1: send this byte with inverted parity
//   code_ready    FIFO can accept a byte (registered !full)
//   host_inhibit  host pulling PS/2 clock low; aborts a frame in flight
//   ps2_clk       PS/2 clock, idle high
//   ps2_data      PS/2 data, idle high
//   busy          frame or inter-frame gap in progress
//   fifo_count    bytes held, including the byte on the wire
//
// state  | meaning
// S_IDLE | lines high, waiting for a queued byte and no inhibit
// S_HIGH | ps2_clk high, current bit driven on ps2_data
// S_LOW  | ps2_clk low, current bit held
// S_GAP  | lines high for GAP_HALVES half-periods after the stop bit
module ps2_kbd_tx #(
  parameter int unsigned CLK_DIV    = 30,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter bit          ODD_PARITY = 1'b1,
  parameter int unsigned GAP_HALVES = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          code_valid,
  input  logic [7:0]                    code_data,
  input  logic                          code_err,
  output logic                          code_ready,
  input  logic                          host_inhibit,
  output logic                          ps2_clk,
  output logic                          ps2_data,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned AW      = $clog2(FIFO_DEPTH);
  localparam int unsigned CW      = AW + 1;
  localparam int unsigned DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned GAP_CYC = GAP_HALVES * CLK_DIV;
  localparam int unsigned GW      = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYC > 0) ? (GAP_CYC - 1) : 0);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  // FIFO storage: {code_err, code_data}
  logic [8:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          push, pop;
  logic [8:0]    head;
  logic          par;

  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [3:0]    bit_q, bit_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [10:0]   frame_q, frame_d;

  assign code_ready = ~full_q;
  assign push       = code_valid & ~full_q;
  assign head       = mem_q[rd_ptr_q];
  assign par        = ODD_PARITY ? ~^head[7:0] : ^head[7:0];

  // ---------------- FIFO ----------------
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    full_d = (count_d == DEPTH_C);
  end

  // Storage is not reset: contents are meaningless once the pointers clear.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {code_err, code_data};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
    end
  end

  // ---------------- frame FSM ----------------
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    frame_d = frame_q;
    pop     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if ((count_q != '0) && !host_inhibit) begin
          state_d = S_HIGH;
          div_d   = '0;
          bit_d   = 4'd0;
          frame_d = {1'b1, par ^ head[8], head[7:0], 1'b0};
        end
      end

      S_HIGH: begin
        if (host_inhibit) begin
          state_d = S_IDLE;
        end else if (div_q == DIV_LAST) begin
          div_d   = '0;
          state_d = S_LOW;
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      S_LOW: begin
        if (host_inhibit) begin
          // Abort without popping: the whole frame is resent later.
          state_d = S_IDLE;
        end else if (div_q == DIV_LAST) begin
          div_d = '0;
          if (bit_q < 4'd10) begin
            bit_d   = bit_q + 4'd1;
            state_d = S_HIGH;
          end else begin
            pop     = 1'b1;
            gap_d   = '0;
            state_d = (GAP_CYC == 0) ? S_IDLE : S_GAP;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      bit_q   <= 4'd0;
      gap_q   <= '0;
      frame_q <= '1;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      frame_q <= frame_d;
    end
  end

  // Lines decode straight from the state flops so reset forces them high
  // without waiting for a clock edge.
  assign ps2_clk    = (state_q != S_LOW);
  assign ps2_data   = ((state_q == S_HIGH) || (state_q == S_LOW)) ? frame_q[bit_q] : 1'b1;
  assign busy       = (state_q != S_IDLE);
  assign fifo_count = count_q;

endmodule
